// File: rtl/axis_hdr_insert_arb_if.sv
// Bundle of per-source stream/header lanes and the single downstream stream/header port.
// The master modport is the arbiter's view; slave is the sources/sink environment's view.
interface axis_hdr_insert_arb_if #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned NUM_SRC      = 4
);
  logic [NUM_SRC-1:0]              s_valid_in;
  logic [NUM_SRC*DATA_WD-1:0]      s_data_in;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in;
  logic [NUM_SRC-1:0]              s_last_in;
  logic [NUM_SRC-1:0]              s_ready_in;

  logic [NUM_SRC-1:0]              s_valid_insert;
  logic [NUM_SRC*DATA_WD-1:0]      s_header_insert;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert;
  logic [NUM_SRC-1:0]              s_ready_insert;

  logic                            m_valid_in;
  logic [DATA_WD-1:0]              m_data_in;
  logic [DATA_BYTE_WD-1:0]         m_keep_in;
  logic                            m_last_in;
  logic                            m_ready_in;

  logic                            m_valid_insert;
  logic [DATA_WD-1:0]              m_header_insert;
  logic [DATA_BYTE_WD-1:0]         m_keep_insert;
  logic                            m_ready_insert;

  modport master (
    input  s_valid_in, s_data_in, s_keep_in, s_last_in,
    output s_ready_in,
    input  s_valid_insert, s_header_insert, s_keep_insert,
    output s_ready_insert,
    output m_valid_in, m_data_in, m_keep_in, m_last_in,
    input  m_ready_in,
    output m_valid_insert, m_header_insert, m_keep_insert,
    input  m_ready_insert
  );

  modport slave (
    output s_valid_in, s_data_in, s_keep_in, s_last_in,
    input  s_ready_in,
    output s_valid_insert, s_header_insert, s_keep_insert,
    input  s_ready_insert,
    input  m_valid_in, m_data_in, m_keep_in, m_last_in,
    output m_ready_in,
    input  m_valid_insert, m_header_insert, m_keep_insert,
    output m_ready_insert
  );
endinterface

// File: rtl/axis_hdr_insert_arb.sv
// Round-robin arbiter granting one source at a time a header beat followed by its packet,
// forwarded combinationally to a single header-insert datapath.
module axis_hdr_insert_arb #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned NUM_SRC      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axis_hdr_insert_arb_if.master        bus,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
  output logic                         busy,
  output logic                         pkt_done,
  output logic                         hdr_err
);
  localparam int unsigned GW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [GW-1:0]           r_grant;
  logic [GW-1:0]           r_last_grant;
  logic [GW-1:0]           w_arb_idx;
  logic                    w_arb_found;
  int unsigned             w_rr_idx;

  logic                    w_hv;
  logic [DATA_WD-1:0]      w_hdr;
  logic [DATA_BYTE_WD-1:0] w_hkeep;
  logic                    w_dv;
  logic [DATA_WD-1:0]      w_data;
  logic [DATA_BYTE_WD-1:0] w_dkeep;
  logic                    w_dlast;
  logic                    w_hkeep_ok;
  logic                    w_hdr_fire;
  logic                    w_last_fire;

  // Search starts one past the last completed grant and wraps, so every requester is reached.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_rr_idx    = 0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      w_rr_idx = (32'(r_last_grant) + off) % NUM_SRC;
      if (!w_arb_found && bus.s_valid_insert[GW'(w_rr_idx)]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = GW'(w_rr_idx);
      end
    end
  end

  // Granted-lane select written as a compare per source so every lane slice is constant.
  always_comb begin
    w_hv    = 1'b0;
    w_hdr   = '0;
    w_hkeep = '0;
    w_dv    = 1'b0;
    w_data  = '0;
    w_dkeep = '0;
    w_dlast = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_grant == GW'(i)) begin
        w_hv    = bus.s_valid_insert[i];
        w_hdr   = bus.s_header_insert[i*DATA_WD +: DATA_WD];
        w_hkeep = bus.s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        w_dv    = bus.s_valid_in[i];
        w_data  = bus.s_data_in[i*DATA_WD +: DATA_WD];
        w_dkeep = bus.s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        w_dlast = bus.s_last_in[i];
      end
    end
  end

  // A contiguous low-aligned mask (including empty and full) has no bit set above a cleared one.
  assign w_hkeep_ok  = ((w_hkeep & (w_hkeep + DATA_BYTE_WD'(1))) == '0);
  assign w_hdr_fire  = (r_state == HDR) && w_hv && bus.m_ready_insert;
  assign w_last_fire = (r_state == DATA) && w_dv && bus.m_ready_in && w_dlast;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      bus.s_ready_insert[i] = (r_state == HDR) && (r_grant == GW'(i)) && bus.m_ready_insert;
      bus.s_ready_in[i]     = (r_state == DATA) && (r_grant == GW'(i)) && bus.m_ready_in;
    end
  end

  always_comb begin
    w_next              = r_state;
    bus.m_valid_insert  = 1'b0;
    bus.m_header_insert = '0;
    bus.m_keep_insert   = '0;
    bus.m_valid_in      = 1'b0;
    bus.m_data_in       = '0;
    bus.m_keep_in       = '0;
    bus.m_last_in       = 1'b0;
    pkt_done            = 1'b0;
    hdr_err             = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_found) w_next = HDR;
      end
      HDR: begin
        bus.m_valid_insert  = w_hv;
        bus.m_header_insert = w_hdr;
        bus.m_keep_insert   = w_hkeep;
        if (w_hdr_fire) begin
          w_next  = DATA;
          hdr_err = !w_hkeep_ok;
        end
      end
      DATA: begin
        bus.m_valid_in = w_dv;
        bus.m_data_in  = w_data;
        bus.m_keep_in  = w_dkeep;
        bus.m_last_in  = w_dlast;
        if (w_last_fire) begin
          w_next   = IDLE;
          pkt_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_SRC - 1);
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_arb_found) r_grant <= w_arb_idx;
      if (w_last_fire) r_last_grant <= r_grant;
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_axis_hdr_insert_arb.sv
// Self-checking bench: randomized sources/sink against a packet-level arbitration model,
// plus directed scenarios pinned by hand-computed expectations.
module tb_axis_hdr_insert_arb;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NP = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] grant_id;
  logic busy, pkt_done, hdr_err;

  axis_hdr_insert_arb_if #(.DATA_WD(DW), .DATA_BYTE_WD(BW), .NUM_SRC(NS)) bus ();

  axis_hdr_insert_arb #(.DATA_WD(DW), .DATA_BYTE_WD(BW), .NUM_SRC(NS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_id(grant_id), .busy(busy), .pkt_done(pkt_done), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  // packet pool and per-source send lists
  logic [31:0] p_hdr [NP];
  logic [3:0]  p_hk  [NP];
  logic [31:0] p_d   [NP][8];
  logic [3:0]  p_dk  [NP][8];
  int          p_n   [NP];
  int          npool = 0;
  int          loaded = 0;
  int          list [NS][64];
  int          head [NS];
  int          cnt  [NS];
  bit          hsent [NS];
  int          beat [NS];
  bit          force_dv [NS];
  int          rmode = 2;
  int          hmode = 1;

  // values the sources / sink currently present
  logic [NS-1:0][DW-1:0] d_hdr, d_data;
  logic [NS-1:0][BW-1:0] d_hk, d_dk;
  logic [NS-1:0]         d_hv, d_dv, d_last;
  logic                  d_mr, d_mri;

  assign bus.s_valid_insert  = d_hv;
  assign bus.s_header_insert = d_hdr;
  assign bus.s_keep_insert   = d_hk;
  assign bus.s_valid_in      = d_dv;
  assign bus.s_data_in       = d_data;
  assign bus.s_keep_in       = d_dk;
  assign bus.s_last_in       = d_last;
  assign bus.m_ready_in      = d_mr;
  assign bus.m_ready_insert  = d_mri;

  // model of the link: owner (-1 = none), whether its header went out, rr pointer, grant
  int own = -1, lastg = NS - 1, gid = 0;
  bit hdone = 0, just_granted = 0;
  int total = 0, bad = 0, cyc = 0;
  int n_done = 0, n_err = 0, n_beats = 0, glen = 0, early = 0, mdone = 0;
  int glog [64];
  logic [31:0] last_hdr = '0;

  logic          e_vi, e_vin, e_last, e_busy, e_done, e_err;
  logic [31:0]   e_hdr, e_data;
  logic [3:0]    e_hk, e_dk, e_sri, e_sr;
  int            m_idx;
  bit            m_found;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [3:0] k);
    for (int j = 0; j <= 4; j++) if (k == 4'((1 << j) - 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_pkt(input int src, input logic [31:0] hdr, input logic [3:0] hk, input int n);
    int p;
    p = npool;
    npool++;
    p_hdr[p] = hdr;
    p_hk[p]  = hk;
    p_n[p]   = n;
    for (int b = 0; b < n; b++) begin
      p_d[p][b]  = $urandom;
      p_dk[p][b] = 4'($urandom_range(1, 15));
    end
    list[src][cnt[src]] = p;
    cnt[src]++;
    loaded++;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      d_hv[i] = 1'b0; d_dv[i] = 1'b0; d_last[i] = 1'b0;
      d_hdr[i] = '0; d_hk[i] = '0; d_data[i] = '0; d_dk[i] = '0;
      if (head[i] < cnt[i]) begin
        int p;
        p = list[i][head[i]];
        d_hv[i]   = !hsent[i];
        d_hdr[i]  = p_hdr[p];
        d_hk[i]   = p_hk[p];
        d_dv[i]   = force_dv[i] || ($urandom_range(0, 3) != 0);
        d_data[i] = p_d[p][beat[i]];
        d_dk[i]   = p_dk[p][beat[i]];
        d_last[i] = (beat[i] == p_n[p] - 1);
      end
    end
    case (rmode)
      0: d_mr = ($urandom_range(0, 2) != 0);
      1: d_mr = ~d_mr;
      default: d_mr = 1'b1;
    endcase
    d_mri = (hmode == 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      head[i] = 0; cnt[i] = 0; hsent[i] = 0; beat[i] = 0; force_dv[i] = 0;
    end
    d_hv = '0; d_dv = '0; d_last = '0; d_hdr = '0; d_hk = '0; d_data = '0; d_dk = '0;
    d_mr = 1'b0; d_mri = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      drive();
    end
  end

  // compare process: checks every cycle, then advances the model by what the edge will do
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_m_valid_in", bus.m_valid_in, 0);
      chk("rst_m_valid_insert", bus.m_valid_insert, 0);
      chk("rst_s_ready_in", bus.s_ready_in, 0);
      chk("rst_s_ready_insert", bus.s_ready_insert, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_hdr_err", hdr_err, 0);
      chk("rst_grant_id", grant_id, 0);
      own = -1; lastg = NS - 1; gid = 0; hdone = 0; just_granted = 0;
      for (int i = 0; i < NS; i++) begin hsent[i] = 0; beat[i] = 0; end
    end else begin
      e_vi = 0; e_vin = 0; e_last = 0; e_done = 0; e_err = 0;
      e_hdr = '0; e_data = '0; e_hk = '0; e_dk = '0; e_sri = '0; e_sr = '0;
      if (own >= 0 && !hdone) begin
        e_vi  = d_hv[own];
        e_hdr = d_hdr[own];
        e_hk  = d_hk[own];
        e_sri = d_mri ? (4'b1 << own) : 4'b0;
        e_err = d_hv[own] && d_mri && !legal(d_hk[own]);
      end else if (own >= 0) begin
        e_vin  = d_dv[own];
        e_data = d_data[own];
        e_dk   = d_dk[own];
        e_last = d_last[own];
        e_sr   = d_mr ? (4'b1 << own) : 4'b0;
        e_done = d_dv[own] && d_mr && d_last[own];
      end
      e_busy = (own >= 0);
      chk("m_valid_insert", bus.m_valid_insert, e_vi);
      chk("m_header_insert", bus.m_header_insert, e_hdr);
      chk("m_keep_insert", bus.m_keep_insert, e_hk);
      chk("m_valid_in", bus.m_valid_in, e_vin);
      chk("m_data_in", bus.m_data_in, e_data);
      chk("m_keep_in", bus.m_keep_in, e_dk);
      chk("m_last_in", bus.m_last_in, e_last);
      chk("s_ready_insert", bus.s_ready_insert, e_sri);
      chk("s_ready_in", bus.s_ready_in, e_sr);
      chk("busy", busy, e_busy);
      chk("pkt_done", pkt_done, e_done);
      chk("hdr_err", hdr_err, e_err);
      chk("grant_id", grant_id, gid);

      if (pkt_done) n_done++;
      if (hdr_err) n_err++;
      if (bus.m_valid_in && bus.m_ready_in) n_beats++;
      if (bus.m_valid_insert && bus.m_ready_insert) last_hdr = bus.m_header_insert;
      if (bus.s_ready_in[2] && !hsent[2]) early++;
      if (just_granted) begin
        glog[glen] = grant_id;
        glen++;
        just_granted = 0;
      end

      if (own < 0) begin
        m_found = 0;
        for (int k = 1; k <= NS; k++) begin
          m_idx = (lastg + k) % NS;
          if (!m_found && d_hv[m_idx]) begin
            m_found = 1; own = m_idx; gid = m_idx; hdone = 0; just_granted = 1;
          end
        end
      end else if (!hdone) begin
        if (d_hv[own] && d_mri) begin hsent[own] = 1; hdone = 1; end
      end else if (d_dv[own] && d_mr) begin
        beat[own]++;
        if (d_last[own]) begin
          head[own]++; beat[own] = 0; hsent[own] = 0; lastg = own; own = -1; mdone++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n;
    bit idle;
    n = 0;
    idle = 0;
    while (!idle && n < max) begin
      tick();
      n++;
      idle = (own < 0);
      for (int i = 0; i < NS; i++) if (head[i] < cnt[i]) idle = 0;
    end
    if (!idle) begin
      total++; bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", max);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    tick(); tick();
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  int d0, b0, g0, e0, r0, n, idles;
  bit started, hit;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant_id", grant_id, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valids", {bus.m_valid_in, bus.m_valid_insert}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // single source 1
    d0 = n_done; b0 = n_beats; e0 = n_err;
    add_pkt(1, 32'hAABBCCDD, 4'b0011, 3);
    n = 0;
    do begin tick(); n++; end while (!bus.m_valid_insert && n < 20);
    chk("t1_hdr_latency", n, 2);
    chk("t1_hdr_value", bus.m_header_insert, 32'hAABBCCDD);
    chk("t1_hdr_keep", bus.m_keep_insert, 4'b0011);
    chk("t1_grant", grant_id, 1);
    wait_idle(200);
    chk("t1_done", n_done - d0, 1);
    chk("t1_beats", n_beats - b0, 3);
    chk("t1_no_err", n_err - e0, 0);

    // all four from reset
    do_reset();
    d0 = n_done; g0 = glen; idles = 0; started = 0;
    for (int s = 0; s < NS; s++) add_pkt(s, $urandom, 4'hF, 2);
    add_pkt(0, $urandom, 4'hF, 2);
    n = 0;
    while (n_done - d0 < 5 && n < 400) begin
      tick();
      n++;
      if (busy) started = 1;
      else if (started) idles++;
    end
    chk("t2_done", n_done - d0, 5);
    chk("t2_grants", glen - g0, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), glog[g0 + k], exp_order[k]);
    chk("t2_idle_gaps", idles, 4);
    wait_idle(50);

    // backpressure: ready toggles
    rmode = 1; force_dv[2] = 1;
    d0 = n_done; b0 = n_beats;
    add_pkt(2, $urandom, 4'hF, 6);
    wait_idle(300);
    chk("t3_beats", n_beats - b0, 6);
    chk("t3_done", n_done - d0, 1);
    rmode = 2; force_dv[2] = 0;

    // illegal header keep
    e0 = n_err;
    add_pkt(0, 32'h12345678, 4'b0101, 2);
    wait_idle(200);
    chk("t4_err", n_err - e0, 1);
    chk("t4_hdr_fwd", last_hdr, 32'h12345678);
    add_pkt(1, 32'h0BADF00D, 4'b0111, 1);
    wait_idle(200);
    chk("t4_legal_no_err", n_err - e0, 1);

    // src2 data before its header is granted
    r0 = early; force_dv[2] = 1;
    add_pkt(0, $urandom, 4'hF, 4);
    add_pkt(2, $urandom, 4'hF, 3);
    wait_idle(300);
    chk("t5_early_ready", early - r0, 0);
    force_dv[2] = 0;

    // reset mid-packet
    d0 = n_done; hit = 0;
    add_pkt(3, $urandom, 4'hF, 4);
    for (int k = 0; k < 100 && !hit; k++) begin
      tick();
      if (own == 3 && hdone && beat[3] == 1) hit = 1;
    end
    chk("t6_reached_beat2", hit, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid_in", bus.m_valid_in, 0);
    chk("t6_rst_ready_in", bus.s_ready_in, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant_id, 0);
    add_pkt(0, $urandom, 4'hF, 2);
    add_pkt(1, $urandom, 4'hF, 2);
    tick(); tick();
    chk("t6_no_done", n_done - d0, 0);
    g0 = glen;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle(400);
    chk("t6_first_grant", (glen > g0) ? glog[g0] : -1, 0);
    chk("t6_done", n_done - d0, 3);

    // randomized traffic
    rmode = 0; hmode = 0;
    for (int k = 0; k < 40; k++) begin
      logic [3:0] hk;
      hk = ($urandom_range(0, 4) != 0) ? 4'((1 << $urandom_range(0, 4)) - 1) : 4'($urandom);
      add_pkt($urandom_range(0, NS - 1), $urandom, hk, $urandom_range(1, 8));
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_idle(6000);
    chk("final_delivered", n_done, loaded);
    chk("final_model_done", n_done, mdone);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
